// File: rtl/fx_pkg.sv
// fx_pkg: shared constants and helpers for the pitch-effect engine
package fx_pkg;
  localparam logic [1:0] FX_NONE    = 2'd0;
  localparam logic [1:0] FX_PORTA   = 2'd1;
  localparam logic [1:0] FX_VIBRATO = 2'd2;
  localparam logic [1:0] FX_MUTE    = 2'd3;
  localparam int NOTE_W = 6;
  localparam int OFFS_W = 3;
  localparam int PORTA_TICK_LOG2_DEF = 18;
  localparam int VIB_TICK_LOG2_DEF   = 16;
  // Vibrato peak magnitude 2*depth+1 (1, 3, 5 or 7)
  function automatic logic [OFFS_W-1:0] vib_max(input logic [1:0] depth);
    return {depth, 1'b1};
  endfunction
endpackage

// File: rtl/fx_pitch_effects_if.sv
// fx_pitch_effects_if: sequencer-side controls and effected outputs of one channel
interface fx_pitch_effects_if;
  import fx_pkg::*;
  logic [NOTE_W-1:0] note_in;
  logic              note_clk;
  logic [1:0]        fx_sel;
  logic [1:0]        fx_optA;
  logic [1:0]        fx_optB;
  logic [NOTE_W-1:0] note_out;
  logic [OFFS_W-1:0] offset_mul;
  logic              offset_dir;
  modport master (
    output note_in, note_clk, fx_sel, fx_optA, fx_optB,
    input  note_out, offset_mul, offset_dir
  );
  modport slave (
    input  note_in, note_clk, fx_sel, fx_optA, fx_optB,
    output note_out, offset_mul, offset_dir
  );
endinterface

// File: rtl/fx_tick_prescaler.sv
// fx_tick_prescaler: free-running divider, one-cycle tick every 2^(BASE+speed) cycles
module fx_tick_prescaler #(
  parameter int BASE = 18
) (
  input  logic       clk50mhz,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       tick
);
  localparam int W = BASE + 4;
  logic [W-1:0] cnt;
  logic [W-1:0] mask;
  assign mask = {W{1'b1}} >> (3'd4 - 3'(speed));
  assign tick = (cnt & mask) == mask;
  // Count continuously; a speed change only moves the tick mask, so the phase is kept
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clear ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fx_pitch_effects.sv
// fx_pitch_effects: portamento and vibrato LFO on a 6-bit note index for one channel
module fx_pitch_effects
  import fx_pkg::*;
#(
  parameter int PORTA_TICK_LOG2 = PORTA_TICK_LOG2_DEF,
  parameter int VIB_TICK_LOG2   = VIB_TICK_LOG2_DEF
) (
  input logic clk50mhz,
  input logic rst_n,
  fx_pitch_effects_if.slave fx
);
  logic [1:0]        nclk_sync;
  logic              nclk_prev;
  logic              note_edge;
  logic              porta_tick;
  logic              vib_tick;
  logic [NOTE_W-1:0] porta_cur;
  logic [OFFS_W-1:0] vib_mag;
  logic [OFFS_W-1:0] vib_lim;
  logic              vib_dir;
  logic              vib_up;

  assign vib_lim = vib_max(fx.fx_optB);

  fx_tick_prescaler #(.BASE(PORTA_TICK_LOG2)) u_porta_div (
    .clk50mhz(clk50mhz), .rst_n(rst_n), .clear(note_edge), .speed(fx.fx_optA), .tick(porta_tick)
  );

  fx_tick_prescaler #(.BASE(VIB_TICK_LOG2)) u_vib_div (
    .clk50mhz(clk50mhz), .rst_n(rst_n), .clear(note_edge), .speed(fx.fx_optA), .tick(vib_tick)
  );

  // Synchronise note_clk and register its rising edge (pulse acts 3 cycles after the pin)
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) begin
      {nclk_prev, nclk_sync} <= '0;
      note_edge <= 1'b0;
    end else begin
      {nclk_prev, nclk_sync} <= {nclk_sync, fx.note_clk};
      note_edge <= nclk_sync[1] & ~nclk_prev;
    end

  // Portamento: track the note outside porta, otherwise creep one step per tick toward it
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) porta_cur <= '0;
    else if (fx.fx_sel != FX_PORTA) porta_cur <= fx.note_in;
    else if (porta_tick && !note_edge && porta_cur != fx.note_in)
      porta_cur <= porta_cur < fx.note_in ? porta_cur + 1'b1 : porta_cur - 1'b1;

  // Vibrato triangle 0..max..0, flipping direction each time it lands back on 0
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) begin
      vib_mag <= '0;
      vib_dir <= 1'b0;
      vib_up  <= 1'b1;
    end else if (fx.fx_sel != FX_VIBRATO || note_edge) begin
      vib_mag <= '0;
      vib_dir <= 1'b0;
      vib_up  <= 1'b1;
    end else if (vib_tick) begin
      if (vib_mag > vib_lim) begin
        vib_mag <= vib_lim;
        vib_up  <= 1'b0;
      end else if (vib_up && vib_mag < vib_lim) begin
        vib_mag <= vib_mag + 1'b1;
        vib_up  <= (vib_mag + 3'd1) != vib_lim;
      end else begin
        vib_mag <= vib_mag - 1'b1;
        vib_up  <= vib_mag == 3'd1;
        vib_dir <= vib_dir ^ (vib_mag == 3'd1);
      end
    end

  // Registered output select
  always_ff @(posedge clk50mhz or negedge rst_n)
    if (!rst_n) begin
      fx.note_out   <= '0;
      fx.offset_mul <= '0;
      fx.offset_dir <= 1'b0;
    end else begin
      fx.note_out   <= fx.fx_sel == FX_MUTE ? '0 : fx.fx_sel == FX_PORTA ? porta_cur : fx.note_in;
      fx.offset_mul <= fx.fx_sel == FX_VIBRATO ? vib_mag : '0;
      fx.offset_dir <= fx.fx_sel == FX_VIBRATO && vib_dir;
    end
endmodule

// File: tb/tb_fx_pitch_effects.sv
// tb_fx_pitch_effects: directed tables, corner sequences and randomized run against a reference model
module tb_fx_pitch_effects;
  import fx_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fx_pitch_effects_if bus();

  fx_pitch_effects #(.PORTA_TICK_LOG2(4), .VIB_TICK_LOG2(3)) dut (
    .clk50mhz(clk),
    .rst_n(rst_n),
    .fx(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  int m_porta, m_mag, m_dir, m_rise, m_pc, m_vc;
  logic [3:0] m_hist;
  int e_note, e_mul, e_dir;

  int chv[$];
  int chc[$];

  typedef struct {
    logic [1:0] sel;
    logic [5:0] note;
    int en;
    int em;
    int ed;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_porta = 0; m_mag = 0; m_dir = 0; m_rise = 1; m_pc = 0; m_vc = 0; m_hist = '0;
  endtask

  function automatic int outv();
    return int'({bus.offset_dir, bus.offset_mul});
  endfunction

  // One clock: drive at negedge, advance the model over the coming posedge, compare after it
  task automatic step(input logic [1:0] sel, input logic [5:0] note, input logic nclk,
                      input logic [1:0] oa, input logic [1:0] ob);
    int pp, vp, mx;
    bit edge_now, pt, vt;
    bus.fx_sel = sel; bus.note_in = note; bus.note_clk = nclk; bus.fx_optA = oa; bus.fx_optB = ob;
    edge_now = m_hist[2] && !m_hist[3];
    pp = 1 << (4 + int'(oa));
    vp = 1 << (3 + int'(oa));
    pt = (m_pc % pp) == pp - 1;
    vt = (m_vc % vp) == vp - 1;
    e_note = sel == 3 ? 0 : sel == 1 ? m_porta : int'(note);
    e_mul  = sel == 2 ? m_mag : 0;
    e_dir  = sel == 2 ? m_dir : 0;
    if (sel != 1) m_porta = int'(note);
    else if (pt && !edge_now) m_porta += int'(note) > m_porta ? 1 : int'(note) < m_porta ? -1 : 0;
    mx = 2 * int'(ob) + 1;
    if (sel != 2 || edge_now) begin
      m_mag = 0; m_dir = 0; m_rise = 1;
    end else if (vt) begin
      if (m_mag > mx) begin
        m_mag = mx; m_rise = 0;
      end else if (m_rise != 0 && m_mag < mx) begin
        m_mag++;
        if (m_mag == mx) m_rise = 0;
      end else begin
        m_mag--;
        m_rise = 0;
        if (m_mag == 0) begin m_dir ^= 1; m_rise = 1; end
      end
    end
    m_pc = edge_now ? 0 : m_pc + 1;
    m_vc = edge_now ? 0 : m_vc + 1;
    m_hist = {m_hist[2:0], nclk};
    @(posedge clk);
    #1;
    cyc_n++;
    vectors++;
    if (int'(bus.note_out) != e_note || int'(bus.offset_mul) != e_mul || int'(bus.offset_dir) != e_dir) begin
      miscompares++;
      $display("FAIL model cycle %0d: note_out %0d want %0d, offset_mul %0d want %0d, offset_dir %0d want %0d",
               cyc_n, bus.note_out, e_note, bus.offset_mul, e_mul, bus.offset_dir, e_dir);
    end
    @(negedge clk);
  endtask

  initial begin
    int last, t13, n0;
    bit found;
    logic nc;
    logic [1:0] rs, ra, rb;
    logic [5:0] rn;
    logic rc;
    int exp4[12];
    tbl[0] = '{2'd0, 6'd25, 25, 0, 0};
    tbl[1] = '{2'd3, 6'd25, 0, 0, 0};
    tbl[2] = '{2'd0, 6'd63, 63, 0, 0};
    tbl[3] = '{2'd2, 6'd40, 40, 0, 0};
    tbl[4] = '{2'd3, 6'd7, 0, 0, 0};
    tbl[5] = '{2'd0, 6'd0, 0, 0, 0};
    tbl[6] = '{2'd1, 6'd5, 0, 0, 0};
    exp4 = '{1, 2, 3, 2, 1, 8, 9, 10, 11, 10, 9, 0};

    // Reset held with live inputs: outputs stay zero
    bus.fx_sel = 2'd0; bus.note_in = 6'd25; bus.note_clk = 1'b0; bus.fx_optA = 2'd0; bus.fx_optB = 2'd3;
    repeat (5) begin
      @(negedge clk);
      chk("reset_hold", int'({bus.note_out, bus.offset_mul, bus.offset_dir}), 0);
    end
    rst_n = 1'b1;
    model_reset();

    // Single-cycle select table
    foreach (tbl[i]) begin
      step(tbl[i].sel, tbl[i].note, 1'b0, 2'd0, 2'd1);
      chk("tbl_note", int'(bus.note_out), tbl[i].en);
      chk("tbl_mul", int'(bus.offset_mul), tbl[i].em);
      chk("tbl_dir", int'(bus.offset_dir), tbl[i].ed);
    end

    // Portamento ascent 10 -> 14, after an edge aligns the prescaler
    step(0, 10, 0, 0, 0);
    step(0, 10, 1, 0, 0);
    repeat (4) step(0, 10, 1, 0, 0);
    chk("porta_start", int'(bus.note_out), 10);
    chv.delete(); chc.delete(); last = int'(bus.note_out);
    repeat (80) begin
      step(1, 14, 1, 0, 0);
      if (int'(bus.note_out) != last) begin last = int'(bus.note_out); chv.push_back(last); chc.push_back(cyc_n); end
    end
    chk("porta_up_count", chv.size(), 4);
    for (int i = 0; i < chv.size() && i < 4; i++) begin
      chk("porta_up_val", chv[i], 11 + i);
      if (i > 0) chk("porta_up_gap", chc[i] - chc[i-1], 16);
    end
    chk("porta_hold", int'(bus.note_out), 14);

    // Descent 14 -> 12 with an edge landing on the tick that would give 12
    chv.delete(); chc.delete(); last = int'(bus.note_out); t13 = -1;
    for (int i = 0; i < 70; i++) begin
      nc = t13 >= 0 && cyc_n + 1 >= t13 + 12;
      step(1, 12, nc, 0, 0);
      if (int'(bus.note_out) != last) begin
        last = int'(bus.note_out); chv.push_back(last); chc.push_back(cyc_n);
        if (last == 13 && t13 < 0) t13 = cyc_n;
      end
    end
    chk("porta_down_count", chv.size(), 2);
    if (chv.size() == 2) begin
      chk("porta_down_first", chv[0], 13);
      chk("porta_down_second", chv[1], 12);
      chk("porta_dropped_tick_gap", chc[1] - chc[0], 32);
    end

    // Vibrato depth 1: 0,1,2,3,2,1,0 then mirrored with dir=1
    step(0, 30, 0, 0, 1);
    step(0, 30, 0, 0, 1);
    step(0, 30, 1, 0, 1);
    repeat (4) step(0, 30, 1, 0, 1);
    chv.delete(); chc.delete(); last = outv();
    repeat (100) begin
      step(2, 30, 1, 0, 1);
      if (outv() != last) begin last = outv(); chv.push_back(last); chc.push_back(cyc_n); end
    end
    chk("vib_count", chv.size(), 12);
    for (int i = 0; i < chv.size() && i < 12; i++) begin
      chk("vib_val", chv[i], exp4[i]);
      if (i > 0) chk("vib_gap", chc[i] - chc[i-1], 8);
    end
    chk("vib_note", int'(bus.note_out), 30);

    // Edge mid-LFO resets magnitude and direction and restarts the prescaler
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(2, 30, 0, 0, 1);
      found = outv() == 2;
    end
    chk("vib_reach_2", int'(found), 1);
    step(2, 30, 1, 0, 1);
    for (int k = 1; k <= 12; k++) begin
      step(2, 30, 1, 0, 1);
      if (k == 4) chk("edge_lfo_zero", outv(), 0);
      if (k == 11) chk("edge_lfo_still_zero", outv(), 0);
      if (k == 12) chk("edge_lfo_first_step", outv(), 1);
    end

    // Depth drop 3 -> 0 while mag=6: clamps to 1 then falls to 0 with dir toggled
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(2, 30, 1, 0, 3);
      found = bus.offset_mul == 3'd6;
    end
    chk("vib_reach_6", int'(found), 1);
    chv.delete(); last = outv();
    repeat (40) begin
      step(2, 30, 1, 0, 0);
      if (outv() != last) begin last = outv(); chv.push_back(last); end
    end
    chk("clamp_changes", int'(chv.size() >= 2), 1);
    if (chv.size() >= 2) begin
      chk("clamp_to_max", chv[0] & 7, 1);
      chk("clamp_fall", chv[1] & 7, 0);
      chk("clamp_dir_toggle", chv[1] >> 3, 1 - (chv[0] >> 3));
    end

    // Async reset mid-slide zeroes outputs without waiting for a clock
    step(0, 30, 1, 0, 0);
    step(0, 30, 1, 0, 0);
    repeat (40) step(1, 50, 1, 0, 0);
    chk("pre_rst_nonzero", int'(bus.note_out >= 6'd30), 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_rst", int'({bus.note_out, bus.offset_mul, bus.offset_dir}), 0);
    @(negedge clk);
    chk("async_rst_hold", int'({bus.note_out, bus.offset_mul, bus.offset_dir}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized run against the model
    rs = 2'd1; ra = 2'd0; rb = 2'd1; rn = 6'd20; rc = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) rs = 2'($urandom_range(3));
      if ($urandom_range(19) == 0) rn = 6'($urandom_range(63));
      if ($urandom_range(199) == 0) ra = 2'($urandom_range(3));
      if ($urandom_range(99) == 0) rb = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) rc = ~rc;
      step(rs, rn, rc, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
